// File: rtl/red_pitaya_dac_cond_pkg.sv
// Shared constants and FSM encoding for the DAC output conditioner.
// Latency: n/a (declarations only). Backpressure: n/a.
// Default widths for the limiter/gain datapath; GAIN_ONE is unity gain at the default RW.
package red_pitaya_dac_cond_pkg;

    localparam int DW_DEF   = 14;
    localparam int RW_DEF   = 16;
    localparam int GAIN_ONE = 2 ** RW_DEF;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_RUN  = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

endpackage

// File: rtl/red_pitaya_dac_cond_lim.sv
// Slew-rate limiter front end: P1 registers the input sample, P2 moves y toward it by at most slew_i.
// Latency: 2 clocks dat_i -> y_o; lim_o is aligned with y_o.
// Backpressure: none; one sample per clock, always accepted.
module red_pitaya_dac_cond_lim
    import red_pitaya_dac_cond_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DW-1:0]        dat_i,
    input  logic [DW-1:0]        slew_i,
    output logic signed [DW-1:0] y_o,
    output logic                 lim_o
);

    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] y_q, y_d;
    logic                 lim_q, lim_d;
    logic signed [DW:0]   diff;
    logic        [DW:0]   mag;

    always_comb begin
        x_d   = dat_i;
        diff  = $signed({x_q[DW-1], x_q}) - $signed({y_q[DW-1], y_q});
        mag   = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
        y_d   = x_q;
        lim_d = 1'b0;
        // The clamped result always lies between old y and x, so DW-bit wrap arithmetic is exact.
        if (slew_i != '0 && mag > {1'b0, slew_i}) begin
            lim_d = 1'b1;
            if (!diff[DW]) begin
                y_d = y_q + $signed(slew_i);
            end else begin
                y_d = y_q - $signed(slew_i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q   <= '0;
            y_q   <= '0;
            lim_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            lim_q <= lim_d;
        end
    end

    assign y_o   = y_q;
    assign lim_o = lim_q;

endmodule

// File: rtl/red_pitaya_dac_cond.sv
// DAC output conditioner: slew limiter, then soft-start/stop gain ramp; DAC_COND_LIMCNT_EN adds a limit-event counter.
// Latency: 4 dac_clk_i cycles dat_i -> dac_o; limit_o travels with its sample.
// Backpressure: none; one sample accepted and produced every clock.
module red_pitaya_dac_cond
    import red_pitaya_dac_cond_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic          en_i,
    input  logic [DW-1:0] set_slew_i,
    input  logic [RW-1:0] set_ramp_i,
    output logic [DW-1:0] dac_o,
    output logic          busy_o,
    output logic          limit_o,
    input  logic          lim_clr_i,
    output logic [31:0]   lim_cnt_o
);

    localparam int          PW    = DW + RW + 1;
    localparam logic [RW:0] G_ONE = {1'b1, {RW{1'b0}}};

    logic signed [DW-1:0] y;
    logic                 lim2;

    red_pitaya_dac_cond_lim #(
        .DW (DW)
    ) u_lim (
        .clk_i  (dac_clk_i),
        .rst_i  (dac_rst_i),
        .dat_i  (dat_i),
        .slew_i (set_slew_i),
        .y_o    (y),
        .lim_o  (lim2)
    );

    state_e        state_q, state_d;
    logic [RW:0]   g_q, g_d;
    logic [RW+1:0] g_sum;
    logic [RW:0]   g_up, g_dn;

    // Saturating ramp steps; a zero step means "jump straight to the end point".
    always_comb begin
        g_sum = {1'b0, g_q} + {2'b00, set_ramp_i};
        g_up  = (set_ramp_i == '0 || g_sum >= {1'b0, G_ONE}) ? G_ONE : g_sum[RW:0];
        g_dn  = (set_ramp_i == '0 || {1'b0, set_ramp_i} >= g_q) ? '0 : g_q - {1'b0, set_ramp_i};
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            ST_OFF: begin
                g_d = '0;
                if (en_i) begin
                    if (set_ramp_i == '0) begin
                        state_d = ST_RUN;
                        g_d     = G_ONE;
                    end else begin
                        state_d = ST_UP;
                    end
                end
            end
            ST_UP: begin
                // A reversal holds g for one clock and then ramps back from where it was.
                if (!en_i) begin
                    state_d = ST_DOWN;
                end else begin
                    g_d = g_up;
                    if (g_up == G_ONE) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                g_d = G_ONE;
                if (!en_i) begin
                    if (set_ramp_i == '0) begin
                        state_d = ST_OFF;
                        g_d     = '0;
                    end else begin
                        state_d = ST_DOWN;
                    end
                end
            end
            ST_DOWN: begin
                if (en_i) begin
                    state_d = ST_UP;
                end else begin
                    g_d = g_dn;
                    if (g_dn == '0) begin
                        state_d = ST_OFF;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                g_d     = '0;
            end
        endcase
    end

    logic signed [PW-1:0] y_ext, g_ext;
    logic signed [PW-1:0] p_q, p_d;
    logic        [DW-1:0] dac_q, dac_d;
    logic                 lim3_q, lim3_d;
    logic                 lim4_q, lim4_d;

    // The product of a DW-bit sample and a gain <= unity fits in DW+RW bits, so the
    // RW-offset slice equals the floor-shifted result.
    always_comb begin
        y_ext  = {{(PW-DW){y[DW-1]}}, y};
        g_ext  = {{(PW-RW-1){1'b0}}, g_q};
        p_d    = y_ext * g_ext;
        dac_d  = p_q[RW +: DW];
        lim3_d = lim2;
        lim4_d = lim3_q;
    end

    logic [RW:0] unused_p_bits;
    assign unused_p_bits = {p_q[PW-1], p_q[RW-1:0]};

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q <= ST_OFF;
            g_q     <= '0;
            p_q     <= '0;
            dac_q   <= '0;
            lim3_q  <= 1'b0;
            lim4_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            dac_q   <= dac_d;
            lim3_q  <= lim3_d;
            lim4_q  <= lim4_d;
        end
    end

    assign dac_o   = dac_q;
    assign busy_o  = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign limit_o = lim4_q;

`ifdef DAC_COND_LIMCNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts the registered P2 flag; clear takes priority over a same-cycle event.
    always_comb begin
        cnt_d = cnt_q;
        if (lim_clr_i) begin
            cnt_d = '0;
        end else if (lim2 && cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lim_cnt_o = cnt_q;
`else
    logic unused_lim_clr;
    assign unused_lim_clr = lim_clr_i;
    assign lim_cnt_o      = 32'd0;
`endif

endmodule

// File: tb/tb_red_pitaya_dac_cond.sv
// Bench for red_pitaya_dac_cond: directed scenarios plus random stimulus, scoreboard against a behavioural model.
module tb_red_pitaya_dac_cond;

    localparam int ONE = 65536;
`ifdef DAC_COND_LIMCNT_EN
    localparam longint CNT_AFTER_SLEW = 9;
`else
    localparam longint CNT_AFTER_SLEW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] dat = '0;
    logic        en = 1'b0;
    logic [13:0] slew = '0;
    logic [15:0] ramp = '0;
    logic        lim_clr = 1'b0;
    logic [13:0] dac;
    logic        busy;
    logic        limit;
    logic [31:0] cnt;

    red_pitaya_dac_cond dut (
        .dac_clk_i  (clk),
        .dac_rst_i  (rst),
        .dat_i      (dat),
        .en_i       (en),
        .set_slew_i (slew),
        .set_ramp_i (ramp),
        .dac_o      (dac),
        .busy_o     (busy),
        .limit_o    (limit),
        .lim_clr_i  (lim_clr),
        .lim_cnt_o  (cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int dac; bit lim; } exp_t;
    typedef struct { bit busy; longint cnt; } now_t;
    exp_t exp_q[$];
    now_t now_q[$];

    int checks = 0;
    int failures = 0;

    // Behavioural model: limiter on the previous sample, gain chasing 0 or unity.
    int     m_x, m_y, m_g;
    bit     m_dir, m_busy, m_pend;
    longint m_cnt;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_g = 0;
        m_dir = 1'b0; m_busy = 1'b0; m_pend = 1'b0; m_cnt = 0;
        exp_q.delete();
        now_q.delete();
        repeat (2) exp_q.push_back('{dac: 0, lim: 1'b0});
    endtask

    // Called just after a falling edge with inputs set; predicts the next rising edge.
    task automatic cyc();
        int d, mag, tgt, s, r;
        bit lim;
        exp_t e;
        now_t n;
        s = int'(slew);
        r = int'(ramp);
        d = m_x - m_y;
        mag = (d < 0) ? -d : d;
        lim = 1'b0;
        if (s == 0 || mag <= s) begin
            m_y = m_x;
        end else begin
            m_y = (d > 0) ? m_y + s : m_y - s;
            lim = 1'b1;
        end
        m_x = int'($signed(dat));

        tgt = en ? ONE : 0;
        if (en != m_dir) begin
            m_dir = en;
            if (!m_busy && r == 0) m_g = tgt;
            else m_busy = 1'b1;
        end else if (m_busy) begin
            if (r == 0) m_g = tgt;
            else if (en) m_g = (m_g + r > ONE) ? ONE : m_g + r;
            else m_g = (m_g - r < 0) ? 0 : m_g - r;
            if (m_g == tgt) m_busy = 1'b0;
        end

`ifdef DAC_COND_LIMCNT_EN
        if (lim_clr) m_cnt = 0;
        else if (m_pend && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        m_pend = lim;
`endif
        e.dac = int'((longint'(m_y) * longint'(m_g)) >>> 16);
        e.lim = lim;
        n.busy = m_busy;
        n.cnt = m_cnt;
        exp_q.push_back(e);
        now_q.push_back(n);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        now_t n;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (exp_q.size() == 0 || now_q.size() == 0) begin
                    check("scoreboard_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    n = now_q.pop_front();
                    check("sb_dac", longint'($signed(dac)), e.dac);
                    check("sb_limit", longint'(limit), longint'(e.lim));
                    check("sb_busy", longint'(busy), longint'(n.busy));
                    check("sb_lim_cnt", longint'(cnt), n.cnt);
                end
            end
        end
    end

    initial begin : driver
        int cur;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dac", longint'(dac), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_limit", longint'(limit), 0);
        check("reset_cnt", longint'(cnt), 0);
        rst = 1'b0;
        model_reset();

        // Bypass: full-scale positive then full-scale negative pass straight through.
        slew = 14'd0; ramp = 16'd0; en = 1'b1;
        dat = 14'h1FFF; cyc();
        dat = 14'h2000; cyc();
        cyc(); cyc();
        check("t1_dac_1fff", longint'($signed(dac)), 8191);
        cyc();
        check("t1_dac_2000", longint'($signed(dac)), -8192);
        check("t1_limit", longint'(limit), 0);

        // Slew: 0 -> 1000 in steps of 100; clear the counter while idle first.
        dat = 14'd0; lim_clr = 1'b1; cyc();
        lim_clr = 1'b0;
        repeat (5) cyc();
        slew = 14'd100; dat = 14'd1000;
        repeat (13) cyc();
        check("t2_dac_final", longint'($signed(dac)), 1000);
        check("t2_limit_final", longint'(limit), 0);
        check("t6_cnt_after_slew", longint'(cnt), CNT_AFTER_SLEW);

        // Clear coincident with a limit event, then an unlimited stream.
        dat = 14'd0; cyc(); cyc();
        lim_clr = 1'b1; cyc();
        lim_clr = 1'b0;
        repeat (12) cyc();
        for (int i = 0; i < 8; i++) begin
            dat = 14'(i * 50);
            cyc();
        end

        // Ramp down, then soft start at quarter steps.
        slew = 14'd0; ramp = 16'h4000; dat = 14'd4000; en = 1'b0;
        repeat (10) cyc();
        en = 1'b1;
        repeat (8) cyc();
        check("t3_dac_run", longint'($signed(dac)), 4000);
        check("t3_busy_run", longint'(busy), 0);

        // Reversal at half gain.
        en = 1'b0;
        repeat (8) cyc();
        en = 1'b1;
        repeat (3) cyc();
        en = 1'b0;
        repeat (8) cyc();
        check("t4_dac_off", longint'($signed(dac)), 0);
        check("t4_busy_off", longint'(busy), 0);

        // Asynchronous reset in the middle of a ramp-up.
        en = 1'b1;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        check("t5_async_dac", longint'(dac), 0);
        check("t5_async_busy", longint'(busy), 0);
        check("t5_async_limit", longint'(limit), 0);
        check("t5_async_cnt", longint'(cnt), 0);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (4) cyc();
        check("t5_stays_off", longint'(busy), 0);

        // Random traffic.
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0)
                ramp = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h6000));
            if ($urandom_range(0, 29) == 0)
                slew = ($urandom_range(0, 3) == 0) ? 14'd0 : 14'($urandom_range(1, 3000));
            if ($urandom_range(0, 5) == 0) begin
                cur = int'($urandom_range(0, 16383)) - 8192;
            end else begin
                cur = cur + int'($urandom_range(0, 600)) - 300;
                if (cur > 8191) cur = 8191;
                if (cur < -8192) cur = -8192;
            end
            dat = 14'(cur);
            lim_clr = ($urandom_range(0, 29) == 0);
            cyc();
        end
        lim_clr = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
